sr_imem_loader: RTL and testbench

//  Instruction memory plus byte-stream program loader; sits directly upstream of the CPU core.

---
 rtl/sr_imem_loader.sv | 130 +++++++++++++
 tb/tb_sr_imem_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_imem_loader.sv
// Instruction memory with byte-stream program loader; holds the core in reset while loading.
// Optional SR_IMEM_LOADER_CHECKSUM_EN adds an XOR checksum output ld_csum.
module sr_imem_loader #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       imAddr,
  output logic [31:0]       imData,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              cpu_go,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              cpu_rst,
  output logic              ld_busy,
  output logic              ld_done
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       ld_csum
`endif
);

  localparam logic [1:0] HOLD = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam int            DEPTH_I = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH = DEPTH_I[ADDR_W:0];

  logic [1:0]      state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] wi_q, wi_d, wi_inc;
  logic [1:0]      bi_q, bi_d;
  logic [23:0]     part_q, part_d;
  logic            cpu_rst_q, done_q;
  logic [31:0]     csum_q, csum_d;
  logic            we;
  logic [31:0]     wdata;
  logic [ADDR_W:0] len_clamp;

  logic [31:0] mem_q [DEPTH_I];

  assign len_clamp = (ld_len > DEPTH) ? DEPTH : ld_len;
  assign wi_inc    = wi_q + (ADDR_W+1)'(1);
  assign wdata     = {byte_data, part_q};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wi_d    = wi_q;
    bi_d    = bi_q;
    part_d  = part_q;
    csum_d  = csum_q;
    we      = 1'b0;
    case (state_q)
      HOLD, RUN: begin
        if (ld_start) begin
          state_d = LOAD;
          len_d   = len_clamp;
          wi_d    = '0;
          bi_d    = '0;
          csum_d  = '0;
        end else if (cpu_go && state_q == HOLD) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (len_q == '0) begin
          state_d = RUN;
        end else if (byte_valid) begin
          bi_d = bi_q + 2'd1;
          if (bi_q == 2'd3) begin
            we     = 1'b1;
            wi_d   = wi_inc;
            csum_d = csum_q ^ wdata;
            if (wi_inc == len_q) state_d = RUN;
          end else begin
            part_d[{bi_q, 3'b000} +: 8] = byte_data;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HOLD;
      len_q     <= '0;
      wi_q      <= '0;
      bi_q      <= '0;
      part_q    <= '0;
      csum_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wi_q      <= wi_d;
      bi_q      <= bi_d;
      part_q    <= part_d;
      csum_q    <= csum_d;
      cpu_rst_q <= (state_d != RUN);
      done_q    <= (state_q == LOAD) && (state_d == RUN);
    end
  end

  // Memory contents survive rst; only a completed word is ever written.
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[wi_q[ADDR_W-1:0]] <= wdata;
  end

  assign imData     = (|imAddr[31:ADDR_W]) ? NOP_WORD
                                           : mem_q[imAddr[ADDR_W-1:0]];
  assign byte_ready = (state_q == LOAD);
  assign ld_busy    = (state_q == LOAD);
  assign cpu_rst    = cpu_rst_q;
  assign ld_done    = done_q;

`ifdef SR_IMEM_LOADER_CHECKSUM_EN
  assign ld_csum = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_q;
`endif

endmodule

// File: tb/tb_sr_imem_loader.sv
// Randomized bench for sr_imem_loader against an array-based memory model.
// Checks handshake timing, priority, reset-mid-load and optional checksum.
module tb_sr_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic        ld_start;
  logic [6:0]  ld_len;
  logic        cpu_go;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        cpu_rst;
  logic        ld_busy;
  logic        ld_done;
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
  logic [31:0] ld_csum;
`endif

  sr_imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .imAddr     (imAddr),
    .imData     (imData),
    .ld_start   (ld_start),
    .ld_len     (ld_len),
    .cpu_go     (cpu_go),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .cpu_rst    (cpu_rst),
    .ld_busy    (ld_busy),
    .ld_done    (ld_done)
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
    ,
    .ld_csum    (ld_csum)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] exp_mem [64];
  bit          known   [64];
  logic [31:0] ld_words [64];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic verify_mem();
    logic [31:0] hi;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      imAddr = i;
      #1;
      if (known[i]) check($sformatf("mem[%0d]", i), imData, exp_mem[i]);
    end
    hi = $urandom;
    if (hi[31:6] == '0) hi[20] = 1'b1;
    imAddr = hi;
    #1;
    check("nop_rand_hi", imData, 32'h0000_0013);
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) ld_words[i] = $urandom;
  endtask

  // Drive one full load of len words from ld_words; checks handshake along the way.
  task automatic do_load(input int len, input bit gaps, input bit go_too);
    int n;
    logic [31:0] x;
    n = (len > 64) ? 64 : len;
    @(negedge clk);
    ld_start = 1'b1;
    ld_len   = len[6:0];
    cpu_go   = go_too;
    @(negedge clk);
    ld_start = 1'b0;
    cpu_go   = 1'b0;
    check("entry_busy", {31'd0, ld_busy}, 32'd1);
    check("entry_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    for (int k = 0; k < 4 * n; k++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        byte_data  = $urandom;
        ld_start   = $urandom_range(0, 1);
        cpu_go     = $urandom_range(0, 1);
        @(negedge clk);
        check("gap_busy", {31'd0, ld_busy}, 32'd1);
        check("gap_done", {31'd0, ld_done}, 32'd0);
      end
      byte_valid = 1'b1;
      byte_data  = ld_words[k / 4][8 * (k % 4) +: 8];
      check("ready", {31'd0, byte_ready}, 32'd1);
      check("early_done", {31'd0, ld_done}, 32'd0);
      @(negedge clk);
      ld_start = 1'b0;
      cpu_go   = 1'b0;
    end
    if (n == 0) @(negedge clk);
    byte_valid = 1'b0;
    check("done_pulse", {31'd0, ld_done}, 32'd1);
    check("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("run_busy", {31'd0, ld_busy}, 32'd0);
    x = '0;
    for (int i = 0; i < n; i++) begin
      exp_mem[i] = ld_words[i];
      known[i]   = 1'b1;
      x ^= ld_words[i];
    end
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
    check("csum", ld_csum, x);
`endif
    @(negedge clk);
    check("done_once", {31'd0, ld_done}, 32'd0);
    check("stay_run", {31'd0, cpu_rst}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst        = 1'b1;
    byte_valid = 1'b0;
    ld_start   = 1'b0;
    cpu_go     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_busy", {31'd0, ld_busy}, 32'd0);
    check("rst_done", {31'd0, ld_done}, 32'd0);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    imAddr     = '0;
    ld_start   = 1'b0;
    ld_len     = '0;
    cpu_go     = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    for (int i = 0; i < 64; i++) begin
      known[i]   = 1'b0;
      exp_mem[i] = '0;
    end
    repeat (2) @(negedge clk);
    apply_reset();
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
    check("rst_csum", ld_csum, 32'd0);
`endif
    // HOLD stays put without a request, then cpu_go releases the core
    @(negedge clk);
    check("hold_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    cpu_go = 1'b1;
    @(negedge clk);
    cpu_go = 1'b0;
    check("go_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("go_busy", {31'd0, ld_busy}, 32'd0);

    ld_words[0] = 32'h0050_0513;
    ld_words[1] = 32'h0010_0593;
    do_load(2, 1'b0, 1'b0);
    verify_mem();

    rand_words(3);
    do_load(3, 1'b1, 1'b0);
    verify_mem();

    apply_reset();
    rand_words(1);
    do_load(1, 1'b0, 1'b1);
    verify_mem();

    do_load(0, 1'b0, 1'b0);
    verify_mem();

    @(negedge clk);
    imAddr = 32'h100;
    #1;
    check("nop_0x100", imData, 32'h0000_0013);

    // Reset after 6 of 8 bytes: word 0 committed, word 1 untouched
    rand_words(2);
    @(negedge clk);
    ld_start = 1'b1;
    ld_len   = 7'd2;
    @(negedge clk);
    ld_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      byte_valid = 1'b1;
      byte_data  = ld_words[k / 4][8 * (k % 4) +: 8];
      @(negedge clk);
    end
    exp_mem[0] = ld_words[0];
    known[0]   = 1'b1;
    apply_reset();
    verify_mem();
    rand_words(2);
    do_load(2, 1'b1, 1'b0);
    verify_mem();

    ld_words[0] = 32'hA5A5_0000;
    ld_words[1] = 32'h0000_5A5A;
    do_load(2, 1'b0, 1'b0);
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
    check("csum_fixed", ld_csum, 32'hA5A5_5A5A);
`endif
    verify_mem();

    rand_words(64);
    do_load(100, 1'b0, 1'b0);
    verify_mem();

    for (int t = 0; t < 4; t++) begin
      rand_words(12);
      do_load($urandom_range(1, 12), 1'b1, 1'b0);
      verify_mem();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
